// File: rtl/mc_proc_pkg.sv
// Shared types and constants for the mc_proc load/store core.
// Build option: MC_PROC_MUL_EN makes opcode 9 a multiply, otherwise it is illegal.
package mc_proc_pkg;

    localparam int OP_MSB  = 31;
    localparam int SEL_BIT = 16;
    localparam int IMM_W   = 16;

    typedef enum logic [3:0] {
        OP_MOV  = 4'd0,
        OP_MOVI = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_LW   = 4'd4,
        OP_SW   = 4'd5,
        OP_AND  = 4'd6,
        OP_BNZ  = 4'd7,
        OP_HALT = 4'd8,
        OP_MUL  = 4'd9
    } opcode_t;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_WB    = 3'd2,
        S_MEM   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    // Opcodes that go through the ALU and finish with a write-back cycle.
    function automatic logic is_alu_op(input opcode_t op);
        logic r;
        r = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND: r = 1'b1;
`ifdef MC_PROC_MUL_EN
            OP_MUL:                 r = 1'b1;
`endif
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_proc_if.sv
// Instruction fetch port plus data memory / peripheral bus of the mc_proc core.
interface mc_proc_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 9,
    parameter int ADDR_W = 8
);
    logic [PC_W-1:0]   pc;
    logic [31:0]       instr;

    // mem_req stays high with addr/wdata/write/sel frozen until the slave
    // answers mem_ready = 1; that cycle completes the access (and carries
    // mem_rdata for loads). mem_ready is meaningless while mem_req = 0.
    logic              mem_req;
    logic              mem_write;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output pc, mem_req, mem_write, mem_sel, mem_addr, mem_wdata,
        input  instr, mem_rdata, mem_ready
    );

    modport slave (
        input  pc, mem_req, mem_write, mem_sel, mem_addr, mem_wdata,
        output instr, mem_rdata, mem_ready
    );

endinterface

// File: rtl/mc_proc_alu.sv
// Combinational ALU of the mc_proc core: ADD, SUB, AND, and MUL when
// MC_PROC_MUL_EN is defined. All results wrap modulo 2^DATA_W.
module mc_proc_alu
    import mc_proc_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  opcode_t           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_AND:  y_o = a_i & b_i;
`ifdef MC_PROC_MUL_EN
            OP_MUL:  y_o = a_i * b_i;
`endif
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_proc_core.sv
// Multi-cycle load/store core: FETCH -> EXEC -> (WB | MEM) -> FETCH, plus HALT.
// Opcode 9 is MUL only when MC_PROC_MUL_EN is defined.
module mc_proc_core
    import mc_proc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 8,
    parameter int PC_W   = 9,
    parameter int ADDR_W = 8
) (
    input  logic      Clock,
    input  logic      Resetn,
    mc_proc_if.master bus,
    output logic      Done,
    output logic      halted,
    output logic      illegal,
    output state_t    state_o
);

    localparam int RIDX_W = $clog2(NREGS);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] g_q, g_d;
    logic              illegal_q, illegal_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_sel_q, mem_sel_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [DATA_W-1:0] rf_q [NREGS];
    logic              rf_we;
    logic [RIDX_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    opcode_t           op;
    logic [RIDX_W-1:0] rx, ry;
    logic [DATA_W-1:0] rx_val, ry_val, imm_ext, alu_y;
    logic [PC_W-1:0]   bnz_target;
    logic              unused_ir;

    assign op         = opcode_t'(ir_q[OP_MSB -: 4]);
    assign rx         = ir_q[OP_MSB-4 -: RIDX_W];
    assign ry         = ir_q[OP_MSB-8 -: RIDX_W];
    assign rx_val     = rf_q[rx];
    assign ry_val     = rf_q[ry];
    assign imm_ext    = DATA_W'(ir_q[IMM_W-1:0]);
    assign bnz_target = PC_W'(ir_q[IMM_W-1:0]);
    assign unused_ir  = ^ir_q;

    mc_proc_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i (op),
        .a_i  (rx_val),
        .b_i  (ry_val),
        .y_o  (alu_y)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            g_q         <= '0;
            illegal_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_sel_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            g_q         <= g_d;
            illegal_q   <= illegal_d;
            mem_write_q <= mem_write_d;
            mem_sel_q   <= mem_sel_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (rf_we) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        g_d         = g_q;
        illegal_d   = illegal_q;
        mem_write_d = mem_write_q;
        mem_sel_d   = mem_sel_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rf_we       = 1'b0;
        rf_waddr    = rx;
        rf_wdata    = g_q;
        Done        = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_d    = bus.instr;
                pc_d    = pc_q + PC_W'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op)
                    OP_MOV, OP_MOVI: begin
                        rf_we    = 1'b1;
                        rf_wdata = (op == OP_MOVI) ? imm_ext : ry_val;
                        Done     = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_BNZ: begin
                        // Overrides the increment already applied in FETCH.
                        if (rx_val != '0) pc_d = bnz_target;
                        Done    = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_LW, OP_SW: begin
                        mem_addr_d  = ADDR_W'(rx_val);
                        mem_wdata_d = ry_val;
                        mem_write_d = (op == OP_SW);
                        mem_sel_d   = ir_q[SEL_BIT];
                        state_d     = S_MEM;
                    end
                    OP_HALT: begin
                        Done    = 1'b1;
                        state_d = S_HALT;
                    end
                    default: begin
                        if (is_alu_op(op)) begin
                            g_d     = alu_y;
                            state_d = S_WB;
                        end else begin
                            illegal_d = 1'b1;
                            Done      = 1'b1;
                            state_d   = S_FETCH;
                        end
                    end
                endcase
            end
            S_WB: begin
                rf_we   = 1'b1;
                Done    = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    rf_we    = !mem_write_q;
                    rf_waddr = ry;
                    rf_wdata = bus.mem_rdata;
                    Done     = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // mem_req follows the state register so an async reset drops it at once.
    assign bus.pc        = pc_q;
    assign bus.mem_req   = (state_q == S_MEM);
    assign bus.mem_write = mem_write_q;
    assign bus.mem_sel   = mem_sel_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    assign halted  = (state_q == S_HALT);
    assign illegal = illegal_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_mc_proc_core.sv
// Directed bench for mc_proc_core: small programs in a behavioural instruction
// memory, a wait-state data memory responder and an expected-access queue.
module tb_mc_proc_core;
    import mc_proc_pkg::*;

    localparam int DATA_W = 32;
    localparam int NREGS  = 8;
    localparam int PC_W   = 9;
    localparam int ADDR_W = 8;
    localparam int EW     = 2 + ADDR_W + DATA_W;

    logic   Clock = 1'b0;
    logic   Resetn;
    logic   Done, halted, illegal;
    state_t state_dbg;

    mc_proc_if #(.DATA_W(DATA_W), .PC_W(PC_W), .ADDR_W(ADDR_W)) bus ();

    mc_proc_core #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .PC_W   (PC_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .bus     (bus),
        .Done    (Done),
        .halted  (halted),
        .illegal (illegal),
        .state_o (state_dbg)
    );

    always #5 Clock = ~Clock;

    logic [31:0]       imem [0:(1<<PC_W)-1];
    logic [DATA_W-1:0] dmem [0:(1<<ADDR_W)-1];

    assign bus.instr = imem[bus.pc];

    int              n_tests = 0;
    int              n_fail  = 0;
    int              cyc, done_cnt, last_done, ill_cyc;
    int              wait_cfg, wait_left, req_len;
    logic            prev_req, fetch_next;
    logic [EW-1:0]   lat;
    int              done_log[$];
    logic [PC_W-1:0] fetch_pcs[$];
    logic [EW-1:0]   exp_q[$];

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [2:0] rx,
                                        input logic [2:0] ry, input logic sel,
                                        input logic [15:0] imm);
        return {op, rx, 1'b0, ry, 4'b0000, sel, imm};
    endfunction

    function automatic logic [EW-1:0] ent(input logic wr, input logic sel,
                                          input logic [ADDR_W-1:0] addr,
                                          input logic [DATA_W-1:0] data);
        return {wr, sel, addr, data};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_imem();
        for (int i = 0; i < (1 << PC_W); i++) imem[i] = enc(OP_HALT, 3'd0, 3'd0, 1'b0, 16'h0);
    endtask

    task automatic reset_book();
        cyc        = 0;
        done_cnt   = 0;
        last_done  = 0;
        ill_cyc    = 0;
        req_len    = 0;
        wait_left  = 0;
        prev_req   = 1'b0;
        fetch_next = 1'b1;
        done_log.delete();
        fetch_pcs.delete();
        bus.mem_ready = 1'b0;
    endtask

    task automatic start_test(input int waits);
        Resetn = 1'b0;
        exp_q.delete();
        wait_cfg = waits;
        repeat (2) @(negedge Clock);
        reset_book();
        Resetn = 1'b1;
    endtask

    // Data memory slave: answers after wait_cfg stall cycles and scores each access.
    task automatic respond();
        logic [EW-1:0] e;
        if (bus.mem_req === 1'b1) begin
            if (!prev_req) begin
                wait_left = wait_cfg;
                req_len   = 0;
                lat       = {bus.mem_write, bus.mem_sel, bus.mem_addr, bus.mem_wdata};
            end
            req_len++;
            if (wait_left > 0) begin
                wait_left--;
                bus.mem_ready = 1'b0;
            end else begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = dmem[bus.mem_addr];
                check("req_hold", {bus.mem_write, bus.mem_sel, bus.mem_addr, bus.mem_wdata}, lat);
                check("req_len", 64'(req_len), 64'(wait_cfg + 1));
                n_tests++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL spurious_access: observed addr %0h expected no access", bus.mem_addr);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("acc_write", bus.mem_write, e[EW-1]);
                    check("acc_sel", bus.mem_sel, e[EW-2]);
                    check("acc_addr", bus.mem_addr, e[DATA_W +: ADDR_W]);
                    if (e[EW-1]) check("acc_wdata", bus.mem_wdata, e[DATA_W-1:0]);
                end
            end
        end else begin
            bus.mem_ready = 1'b0;
        end
        prev_req = bus.mem_req;
    endtask

    task automatic sample();
        if (fetch_next && halted !== 1'b1) fetch_pcs.push_back(bus.pc);
        fetch_next = (Done === 1'b1);
        if (Done === 1'b1) begin
            done_cnt++;
            last_done = cyc;
            done_log.push_back(cyc);
        end
        if (illegal === 1'b1 && ill_cyc == 0) ill_cyc = cyc;
    endtask

    task automatic cycle();
        cyc++;
        respond();
        #1;
        sample();
        @(negedge Clock);
    endtask

    task automatic run_to_halt(input int budget);
        while (halted !== 1'b1 && cyc < budget) cycle();
        check("halt_reached", halted, 1'b1);
    endtask

    initial begin
        logic [PC_W-1:0] exp_pcs[$];
        logic [DATA_W-1:0] mul_exp;

        Resetn        = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) dmem[i] = '0;
        dmem[8'h10] = 32'h0000_ABCD;
        fill_imem();
        repeat (2) @(negedge Clock);

        // Reset values
        check("rst_pc", bus.pc, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_write", bus.mem_write, 0);
        check("rst_mem_sel", bus.mem_sel, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_done", Done, 0);
        check("rst_halted", halted, 0);
        check("rst_illegal", illegal, 0);
        check("rst_state", state_dbg, S_FETCH);

        // Arithmetic, wrap-around, AND, MOV, rx == ry, Done timing
        fill_imem();
        imem[0]  = enc(OP_MOVI, 3'd1, 3'd0, 1'b0, 16'd5);
        imem[1]  = enc(OP_MOVI, 3'd2, 3'd0, 1'b0, 16'd3);
        imem[2]  = enc(OP_SUB,  3'd1, 3'd2, 1'b0, 16'd0);
        imem[3]  = enc(OP_MOVI, 3'd7, 3'd0, 1'b0, 16'h40);
        imem[4]  = enc(OP_SW,   3'd7, 3'd1, 1'b0, 16'd0);
        imem[5]  = enc(OP_MOVI, 3'd0, 3'd0, 1'b0, 16'd0);
        imem[6]  = enc(OP_MOVI, 3'd3, 3'd0, 1'b0, 16'd1);
        imem[7]  = enc(OP_SUB,  3'd0, 3'd3, 1'b0, 16'd0);
        imem[8]  = enc(OP_SW,   3'd7, 3'd0, 1'b0, 16'd0);
        imem[9]  = enc(OP_MOVI, 3'd4, 3'd0, 1'b0, 16'h0FF0);
        imem[10] = enc(OP_MOVI, 3'd5, 3'd0, 1'b0, 16'h3C3C);
        imem[11] = enc(OP_AND,  3'd4, 3'd5, 1'b0, 16'd0);
        imem[12] = enc(OP_SW,   3'd7, 3'd4, 1'b0, 16'd0);
        imem[13] = enc(OP_ADD,  3'd5, 3'd5, 1'b0, 16'd0);
        imem[14] = enc(OP_SW,   3'd7, 3'd5, 1'b0, 16'd0);
        imem[15] = enc(OP_MOV,  3'd6, 3'd5, 1'b0, 16'd0);
        imem[16] = enc(OP_ADD,  3'd6, 3'd1, 1'b0, 16'd0);
        imem[17] = enc(OP_SW,   3'd7, 3'd6, 1'b0, 16'd0);
        start_test(0);
        exp_q.push_back(ent(1'b1, 1'b0, 8'h40, 32'd2));
        exp_q.push_back(ent(1'b1, 1'b0, 8'h40, 32'hFFFF_FFFF));
        exp_q.push_back(ent(1'b1, 1'b0, 8'h40, 32'h0000_0C30));
        exp_q.push_back(ent(1'b1, 1'b0, 8'h40, 32'h0000_7878));
        exp_q.push_back(ent(1'b1, 1'b0, 8'h40, 32'h0000_787A));
        run_to_halt(300);
        while (done_log.size() < 3) done_log.push_back(-1);
        check("t1_done_c0", 64'(done_log[0]), 64'd2);
        check("t1_done_c1", 64'(done_log[1]), 64'd4);
        check("t1_done_c2", 64'(done_log[2]), 64'd7);
        repeat (8) cycle();
        check("t1_done_count", 64'(done_cnt), 64'd19);
        check("t1_pc_frozen", bus.pc, 19);
        check("t1_halted", halted, 1'b1);
        check("t1_illegal", illegal, 1'b0);
        check("t1_exp_left", 64'(exp_q.size()), 64'd0);

        // Wait states, mem_sel, load write-back
        fill_imem();
        imem[0] = enc(OP_MOVI, 3'd3, 3'd0, 1'b0, 16'h10);
        imem[1] = enc(OP_MOVI, 3'd4, 3'd0, 1'b0, 16'hABCD);
        imem[2] = enc(OP_SW,   3'd3, 3'd4, 1'b1, 16'd0);
        imem[3] = enc(OP_LW,   3'd3, 3'd2, 1'b0, 16'd0);
        imem[4] = enc(OP_MOVI, 3'd7, 3'd0, 1'b0, 16'h20);
        imem[5] = enc(OP_SW,   3'd7, 3'd2, 1'b0, 16'd0);
        start_test(3);
        exp_q.push_back(ent(1'b1, 1'b1, 8'h10, 32'h0000_ABCD));
        exp_q.push_back(ent(1'b0, 1'b0, 8'h10, 32'h0));
        exp_q.push_back(ent(1'b1, 1'b0, 8'h20, 32'h0000_ABCD));
        run_to_halt(300);
        check("t2_halt_done_cycle", 64'(last_done), 64'd26);
        check("t2_exp_left", 64'(exp_q.size()), 64'd0);

        // BNZ taken / not taken and pc wrap
        fill_imem();
        imem[9'h000] = enc(OP_BNZ,  3'd6, 3'd0, 1'b0, 16'h10);
        imem[9'h001] = enc(OP_MOVI, 3'd6, 3'd0, 1'b0, 16'd1);
        imem[9'h002] = enc(OP_BNZ,  3'd6, 3'd0, 1'b0, 16'h20);
        imem[9'h020] = enc(OP_BNZ,  3'd6, 3'd0, 1'b0, 16'h1FF);
        imem[9'h1FF] = enc(OP_MOVI, 3'd2, 3'd0, 1'b0, 16'h99);
        imem[9'h010] = enc(OP_MOVI, 3'd7, 3'd0, 1'b0, 16'h48);
        imem[9'h011] = enc(OP_SW,   3'd7, 3'd2, 1'b0, 16'd0);
        start_test(1);
        exp_q.push_back(ent(1'b1, 1'b0, 8'h48, 32'h99));
        exp_pcs = '{9'h000, 9'h001, 9'h002, 9'h020, 9'h1FF, 9'h000, 9'h010, 9'h011, 9'h012};
        run_to_halt(300);
        check("t3_fetch_count", 64'(fetch_pcs.size()), 64'(exp_pcs.size()));
        for (int i = 0; i < exp_pcs.size(); i++) begin
            if (i < fetch_pcs.size()) check($sformatf("t3_fetch_pc%0d", i), fetch_pcs[i], exp_pcs[i]);
        end
        repeat (4) cycle();
        check("t3_pc_frozen", bus.pc, 9'h013);
        check("t3_exp_left", 64'(exp_q.size()), 64'd0);

        // Illegal opcode is sticky and acts as a NOP; opcode 9 depends on build
`ifdef MC_PROC_MUL_EN
        mul_exp = 32'h369;
`else
        mul_exp = 32'h3;
`endif
        fill_imem();
        imem[0] = enc(OP_MOVI, 3'd1, 3'd0, 1'b0, 16'h123);
        imem[1] = enc(4'hF,    3'd1, 3'd1, 1'b0, 16'hFFFF);
        imem[2] = enc(OP_MOVI, 3'd2, 3'd0, 1'b0, 16'd3);
        imem[3] = enc(4'h9,    3'd2, 3'd1, 1'b0, 16'd0);
        imem[4] = enc(OP_MOVI, 3'd7, 3'd0, 1'b0, 16'h50);
        imem[5] = enc(OP_SW,   3'd7, 3'd1, 1'b0, 16'd0);
        imem[6] = enc(OP_SW,   3'd7, 3'd2, 1'b0, 16'd0);
        start_test(0);
        exp_q.push_back(ent(1'b1, 1'b0, 8'h50, 32'h123));
        exp_q.push_back(ent(1'b1, 1'b0, 8'h50, mul_exp));
        run_to_halt(300);
        check("t4_illegal_first_cycle", 64'(ill_cyc), 64'd5);
        check("t4_illegal_sticky", illegal, 1'b1);
        check("t4_done_count", 64'(done_cnt), 64'd8);
        check("t4_exp_left", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset while a load is stalled
        fill_imem();
        imem[0] = enc(OP_MOVI, 3'd3, 3'd0, 1'b0, 16'h10);
        imem[1] = enc(OP_LW,   3'd3, 3'd4, 1'b0, 16'd0);
        start_test(20);
        repeat (7) cycle();
        check("t5_req_before_reset", bus.mem_req, 1'b1);
        #2;
        Resetn = 1'b0;
        #1;
        check("t5_req_async_drop", bus.mem_req, 1'b0);
        check("t5_pc_async_reset", bus.pc, 0);
        check("t5_state_async_reset", state_dbg, S_FETCH);
        @(negedge Clock);
        fill_imem();
        imem[0] = enc(OP_MOVI, 3'd7, 3'd0, 1'b0, 16'h60);
        imem[1] = enc(OP_SW,   3'd7, 3'd7, 1'b0, 16'd0);
        imem[2] = enc(OP_SW,   3'd7, 3'd4, 1'b0, 16'd0);
        exp_q.delete();
        exp_q.push_back(ent(1'b1, 1'b0, 8'h60, 32'h60));
        exp_q.push_back(ent(1'b1, 1'b0, 8'h60, 32'h0));
        wait_cfg = 1;
        reset_book();
        Resetn = 1'b1;
        run_to_halt(300);
        if (fetch_pcs.size() == 0) fetch_pcs.push_back('1);
        check("t5_first_fetch_pc", fetch_pcs[0], 0);
        check("t5_exp_left", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_proc_core.md
# mc_proc_core

Parametrised multi-cycle load/store processor core. Fetches instructions from an external asynchronous-read instruction memory through a program counter, executes them over a register file of NREGS × DATA_W bits, and accesses data memory/peripherals through a req/ready handshake that tolerates wait states. Adds an AND operation, a conditional branch (BNZ), a HALT instruction and sticky illegal-opcode detection. It is the next-generation core for the lab processor top level.

## Interface
- DATA_W, 32, datapath, register and bus width
- NREGS, 8, number of general registers (power of two, 2..16); RIDX_W = $clog2(NREGS)
- PC_W, 9, program counter / instruction-memory address width
- ADDR_W, 8, data-memory address width
- Clock  in  1  clock, rising edge
- Resetn  in  1  asynchronous, active-low reset
- pc  out  PC_W  instruction-memory address
- instr  in  32  instruction word for address pc, valid in the same cycle
- mem_req  out  1  data access request
- mem_write  out  1  1 = store, 0 = load
- mem_sel  out  1  target select (0 = data memory, 1 = peripheral), taken from IR[16]
- mem_addr  out  ADDR_W  data address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  load data, valid when mem_ready = 1
- mem_ready  in  1  access completes in this cycle
- Done  out  1  high for exactly the final cycle of each instruction
- halted  out  1  core stopped by HALT
- illegal  out  1  sticky, an undefined opcode was fetched

## Operation
- Instruction fields: op = instr[31:28]; rx = instr[27 -: RIDX_W]; ry = instr[23 -: RIDX_W]; sel = instr[16]; imm = instr[15:0], zero-extended or truncated to DATA_W.
- Opcodes: 0 MOV R[rx] ← R[ry]; 1 MOVI R[rx] ← imm; 2 ADD R[rx] ← R[rx]+R[ry]; 3 SUB R[rx] ← R[rx]−R[ry]; 4 LW R[ry] ← M[R[rx]]; 5 SW M[R[rx]] ← R[ry]; 6 AND R[rx] ← R[rx]&R[ry]; 7 BNZ: if R[rx] ≠ 0, pc ← imm[PC_W-1:0]; 8 HALT. All other opcodes are illegal.
- Arithmetic is modulo 2^DATA_W and has no flags. Operands are read before write-back, so rx == ry is legal: ADD R2,R2 doubles R2.
- mem_addr = R[rx][ADDR_W-1:0].
- FSM states:
  - FETCH → EXEC. IR ← instr; pc ← pc+1, wrapping from 2^PC_W−1 to 0.
  - EXEC:
    - MOV, MOVI, BNZ: complete here, Done = 1, → FETCH.
    - ALU ops: G ← result, → WB.
    - LW/SW: load the address/wdata/write/sel registers, → MEM.
    - HALT: Done = 1, → HALT.
    - Illegal: illegal ← 1, Done = 1, → FETCH (executes as NOP).
  - WB: R[rx] ← G, Done = 1, → FETCH.
  - MEM: mem_req = 1; stay in MEM while mem_ready = 0. When mem_ready = 1: LW writes R[ry] ← mem_rdata; Done = 1; → FETCH.
  - HALT: halted = 1. The core stays here until reset; pc is frozen and Done stays 0.

## Timing
- Cycle counts: MOV/MOVI/BNZ/HALT/illegal take 2 cycles. ALU ops take 3. LW/SW take 3 + number of wait cycles.
- A taken BNZ overrides the FETCH increment. The target instruction is fetched in the next cycle.
- mem_addr, mem_wdata, mem_write and mem_sel are registered and held stable for the whole time mem_req = 1. mem_req deasserts in the cycle after mem_ready is seen.
- mem_ready is ignored when mem_req = 0.
- Reset values: pc = 0, all registers = 0, IR = 0, G = 0, state = FETCH, mem_req = 0, mem_write = 0, mem_sel = 0, mem_addr = 0, mem_wdata = 0, Done = 0, halted = 0, illegal = 0.
- Reset asserted mid-access drops mem_req immediately (asynchronously). No register write occurs for the aborted access.

## Configuration
- MC_PROC_MUL_EN defined: opcode 9 is MUL, R[rx] ← low DATA_W bits of R[rx]×R[ry]. It takes 3 cycles, the same as the other ALU ops.
- MC_PROC_MUL_EN undefined: opcode 9 is illegal and no multiplier is synthesised.

## Structure
- Package mc_proc_pkg holds:
  - the opcode enum (4 bits) and the FSM state enum;
  - the field position constants (OP_MSB = 31, SEL_BIT = 16, IMM_W = 16).
- One sub-module, mc_proc_alu (DATA_W parameter): a combinational ADD/SUB/AND/(MUL) unit selected by opcode.
- The register file, FSM and PC live in mc_proc_core.

## Test plan
- MOVI R1,5; MOVI R2,3; SUB R1,R2 → R1 = 2; Done pulses at cycles 2, 4 and 7.
- MOVI R0,0; SUB R0, R1 holding 1 → R0 = 0xFFFFFFFF (wrap-around).
- SW with R3 = 0x10, R4 = 0xABCD, mem_ready delayed 3 cycles → mem_req high 4 cycles with mem_addr = 0x10 and mem_wdata = 0xABCD stable. A following LW from address 0x10 with rdata = 0xABCD → destination register = 0xABCD.
- BNZ R5,0x20 with R5 = 1 → pc = 0x20 on the next FETCH. With R5 = 0 → pc continues sequentially. pc at 0x1FF increments to 0x000.
- Opcode 0xF → illegal = 1 and stays 1, register file unchanged, execution continues. HALT → halted = 1, pc frozen, no further Done.
- Resetn pulsed low while in MEM waiting on mem_ready → mem_req = 0 immediately, pc = 0, and after release the core fetches from address 0.
